// File: rtl/reg_bus_arbiter_pkg.sv
// Shared constants and state type for the register-bus arbiter.
// Pure declarations: no latency, no backpressure.
package reg_bus_pkg;
  localparam int NREQ     = 8;
  localparam int SEL_W    = 3;
  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;
endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
// Wires only: no latency, no backpressure.
interface reg_bus_arbiter_if;
  import reg_bus_pkg::*;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   grant;
  logic [SEL_W-1:0]  Sel;
  logic              bus_busy;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (input req, output grant, Sel, bus_busy, hold_cnt);
  modport slave  (output req, input grant, Sel, bus_busy, hold_cnt);
endinterface

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit after ptr, wrapping, wins.
// Combinational, zero latency; no backpressure.
module rr_pick
  import reg_bus_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  logic [NREQ-1:0]  rotReq;
  logic [SEL_W-1:0] offset;

  always_comb begin
    rotReq = '0;
    offset = '0;
    found  = 1'b0;
    // rotReq[0] is the index just after ptr, so ptr itself lands at the top
    for (int i = 0; i < NREQ; i++) begin
      rotReq[i] = req[ptr + SEL_W'(i + 1)];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rotReq[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
    winner = ptr + offset + SEL_W'(1);
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin owner of the 8:1 register read bus, tenure capped at MAX_HOLD cycles.
// Grant is registered (1-cycle latency); a dropped req is honoured one cycle later.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int MAX_HOLD = reg_bus_pkg::MAX_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  reg_bus_arbiter_if.master  bus
);

  state_t            state, nextState;
  logic [NREQ-1:0]   grantR, nextGrant;
  logic [SEL_W-1:0]  selR, nextSel;
  logic [SEL_W-1:0]  ptrR, nextPtr;
  logic [HOLD_W-1:0] holdR, nextHold;
  logic [SEL_W-1:0]  winner;
  logic              found;

  rr_pick u_pick (
    .req    (bus.req),
    .ptr    (ptrR),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grantR <= '0;
      selR   <= '0;
      ptrR   <= SEL_W'(NREQ - 1);
      holdR  <= '0;
    end else begin
      state  <= nextState;
      grantR <= nextGrant;
      selR   <= nextSel;
      ptrR   <= nextPtr;
      holdR  <= nextHold;
    end
  end

  always_comb begin
    nextState = state;
    nextGrant = grantR;
    nextSel   = selR;
    nextPtr   = ptrR;
    nextHold  = holdR;
    unique case (state)
      IDLE: begin
        if (found) begin
          nextState = OWN;
          nextGrant = NREQ'(1) << winner;
          nextSel   = winner;
          nextPtr   = winner;
          nextHold  = '0;
        end
      end
      OWN: begin
        if (bus.req[ptrR] && (holdR < HOLD_W'(MAX_HOLD - 1))) begin
          nextHold = holdR + HOLD_W'(1);
        end else if (found) begin
          // Owner sits last in rotation, so it only re-wins when alone
          nextGrant = NREQ'(1) << winner;
          nextSel   = winner;
          nextPtr   = winner;
          nextHold  = '0;
        end else begin
          nextState = IDLE;
          nextGrant = '0;
          nextHold  = '0;
        end
      end
      default: begin
        nextState = IDLE;
        nextGrant = '0;
        nextHold  = '0;
      end
    endcase
  end

  assign bus.grant    = grantR;
  assign bus.Sel      = selR;
  assign bus.bus_busy = |grantR;
  assign bus.hold_cnt = holdR;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
module tb_reg_bus_arbiter;
  localparam int MH = 4;

  typedef struct {
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic [3:0] h;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  reg_bus_arbiter_if bus();

  reg_bus_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];

  // Reference model: who owns the bus, for how long, and who owned it last
  int owner = -1;
  int lastOwner = 7;
  int tenure = 0;
  int parkSel = 0;

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic modelReset();
    owner = -1;
    lastOwner = 7;
    tenure = 0;
    parkSel = 0;
  endtask

  task automatic modelStep(input logic [7:0] r);
    int w;
    if (owner >= 0 && r[owner] && tenure < MH - 1) begin
      tenure++;
    end else begin
      w = pick(r, lastOwner);
      tenure = 0;
      owner = w;
      if (w >= 0) begin
        lastOwner = w;
        parkSel = w;
      end
    end
  endtask

  task automatic cycle(input logic [7:0] r);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    modelStep(r);
    e.g = (owner >= 0) ? (8'd1 << owner) : 8'd0;
    e.s = 3'(parkSel);
    e.b = (owner >= 0);
    e.h = 4'(tenure);
    q.push_back(e);
  endtask

  task automatic hold(input logic [7:0] r, input int n);
    for (int i = 0; i < n; i++) cycle(r);
  endtask

  task automatic checkResetOutputs(input string tag);
    checks++;
    if (bus.grant !== 8'h00 || bus.Sel !== 3'd0 || bus.bus_busy !== 1'b0 || bus.hold_cnt !== 4'd0) begin
      errors++;
      $display("FAIL %s: grant=%h Sel=%0d busy=%b hold=%0d, expected all zero",
               tag, bus.grant, bus.Sel, bus.bus_busy, bus.hold_cnt);
    end
  endtask

  // Asserts reset away from the edge and checks outputs clear before any clock
  task automatic pulseReset();
    @(negedge clk);
    bus.req = 8'h00;
    #2 reset = 1'b1;
    #1 checkResetOutputs("async_reset");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares every presented output cycle against the scoreboard
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.grant !== e.g || bus.Sel !== e.s || bus.bus_busy !== e.b || bus.hold_cnt !== e.h) begin
        errors++;
        $display("FAIL cycle%0d: got grant=%h Sel=%0d busy=%b hold=%0d, expected grant=%h Sel=%0d busy=%b hold=%0d",
                 cyc, bus.grant, bus.Sel, bus.bus_busy, bus.hold_cnt, e.g, e.s, e.b, e.h);
      end
    end
  end

  initial begin
    logic [7:0] r;
    bus.req = 8'h00;
    #1 checkResetOutputs("power_on_reset");
    modelReset();
    @(negedge clk);
    reset = 1'b0;

    hold(8'h00, 2);
    // single requester past the hold limit
    hold(8'h08, 10);
    // early release, Sel parks at 1
    hold(8'h02, 2);
    hold(8'h00, 3);
    // full contention from reset
    pulseReset();
    hold(8'hFF, 40);
    hold(8'h00, 2);
    // owner 5 drops while 2 and 6 rise
    hold(8'h20, 2);
    hold(8'h44, 3);
    hold(8'h00, 2);
    // owner 7 timing out while 0 arrives
    hold(8'h80, 4);
    hold(8'h81, 10);
    hold(8'h80, 3);
    hold(8'h00, 2);
    // reset mid-tenure with grant=04, then req[0] wins
    hold(8'h04, 2);
    pulseReset();
    hold(8'h81, 3);
    hold(8'h00, 2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        pulseReset();
      end
      case ($urandom_range(0, 3))
        0: r = 8'h00;
        1: r = 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom);
      endcase
      hold(r, $urandom_range(1, 6));
    end
    hold(8'h00, 2);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
